wb_port_arbiter: RTL and testbench

Shares the single register-file write port of the 54-instruction CPU between the main pipeline writeback stage (requester A) and long-latency producers such as the divider, CP0 and load completion (requester B). It resolves the destination register from the instruction field select code, buffers B results in a 2-entry queue, and drains B with starvation protection. It also keeps a per-register pending scoreboard so decode can stall on outstanding B destinations. The block sits between writeback and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 32 +++
 rtl/wb_fifo2.sv | 67 ++++++
 rtl/wb_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared select codes, constants, FSM encoding and queue entry
//               type for the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    // Destination select codes for the A requester
    localparam logic [1:0] SEL_RD = 2'b00;  // instr[15:11]
    localparam logic [1:0] SEL_RT = 2'b01;  // instr[20:16]
    localparam logic [1:0] SEL_RA = 2'b10;  // link register
    localparam logic [1:0] SEL_RS = 2'b11;  // instr[25:21]

    localparam logic [4:0] REG_RA = 5'd31;

    // Cycles a B head may wait before the port is forced to B
    localparam int STARVE_MAX = 4;

    typedef enum logic [0:0] {
        ST_NORM  = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo2
// Description : Small {dest, data} FIFO buffering long-latency B results.
//               Push is ignored when full, pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo2
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign full   = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array; contents are meaningless while the count says empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset discards everything queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between pipeline
//               writeback (A) and queued long-latency results (B), with
//               starvation protection and a pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [31:0] a_instr,
    input  logic [1:0]  a_sel,
    input  logic [31:0] a_data,
    input  logic        b_issue,
    input  logic [4:0]  b_issue_dest,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_dest,
    input  logic [31:0] b_data,
    output logic        stall_a,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy,
    output logic        err
);

    import wb_port_arbiter_pkg::*;

    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [4:0]          w_a_dest;
    logic                w_grant_a;
    logic                w_drain;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    wb_entry_t           w_head;
    wb_entry_t           w_push_entry;
    logic [31:0]         w_busy_nxt;
    logic                w_unused;

    // Instruction bits outside the register fields never affect the address
    assign w_unused = ^{a_instr[31:26], a_instr[10:0]};

    assign b_ready      = !w_full;
    assign w_push       = b_valid && !w_full;
    assign w_push_entry = '{dest: b_dest, data: b_data};
    assign stall_a      = (r_state == ST_FORCE);

    wb_fifo2 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_drain),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Resolve the A destination register from the select code
    always_comb begin
        w_a_dest = a_instr[15:11];
        case (a_sel)
            SEL_RD:  w_a_dest = a_instr[15:11];
            SEL_RT:  w_a_dest = a_instr[20:16];
            SEL_RA:  w_a_dest = REG_RA;
            SEL_RS:  w_a_dest = a_instr[25:21];
            default: w_a_dest = a_instr[15:11];
        endcase
    end

    // Port grant, starvation count and next state; FORCE is entered on the
    // same edge that brings the wait count up to STARVE_MAX
    always_comb begin
        w_grant_a   = 1'b0;
        w_drain     = 1'b0;
        w_state_nxt = ST_NORM;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_NORM: begin
                w_grant_a = a_valid;
                w_drain   = !a_valid && !w_empty;
            end
            ST_FORCE: begin
                w_drain   = !w_empty;
            end
            default: begin
                w_grant_a = 1'b0;
                w_drain   = 1'b0;
            end
        endcase
        if (!w_empty && !w_drain) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        if ((r_state == ST_NORM) && (w_cnt_nxt == c_CNT_W'(STARVE_MAX))) begin
            w_state_nxt = ST_FORCE;
        end
    end

    // FSM state and starvation counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORM;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered register-file write; r0 targets still consume the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (w_grant_a) begin
            rf_we    <= (w_a_dest != 5'd0);
            rf_waddr <= w_a_dest;
            rf_wdata <= a_data;
        end else if (w_drain) begin
            rf_we    <= (w_head.dest != 5'd0);
            rf_waddr <= w_head.dest;
            rf_wdata <= w_head.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard update: clear on drain, then set on issue so the set wins
    always_comb begin
        w_busy_nxt = busy;
        if (w_drain) begin
            w_busy_nxt[w_head.dest] = 1'b0;
        end
        if (b_issue) begin
            w_busy_nxt[b_issue_dest] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register and sticky protocol-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= w_busy_nxt;
            if (stall_a && a_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int c_STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [31:0] a_instr;
    logic [1:0]  a_sel;
    logic [31:0] a_data;
    logic        b_issue;
    logic [4:0]  b_issue_dest;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_dest;
    logic [31:0] b_data;
    logic        stall_a;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        err;

    int n_vec  = 0;
    int n_fail = 0;

    wb_port_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (c_STARVE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_instr      (a_instr),
        .a_sel        (a_sel),
        .a_data       (a_data),
        .b_issue      (b_issue),
        .b_issue_dest (b_issue_dest),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_dest       (b_dest),
        .b_data       (b_data),
        .stall_a      (stall_a),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid      = 1'b0;
        a_instr      = '0;
        a_sel        = 2'b00;
        a_data       = '0;
        b_issue      = 1'b0;
        b_issue_dest = '0;
        b_valid      = 1'b0;
        b_dest       = '0;
        b_data       = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_vec++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        n_vec++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall_a: got %b want 0", stall_a); end
        n_vec++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
    endtask

    task automatic test_a_write();
        logic [4:0] exp_addr [4];
        exp_addr[0] = 5'd8;
        exp_addr[1] = 5'd10;
        exp_addr[2] = 5'd31;
        exp_addr[3] = 5'd9;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            a_valid = 1'b1;
            a_instr = 32'h012A4020;
            a_sel   = 2'(s);
            a_data  = 32'hA000_0000 + 32'(s);
            tick();
            n_vec++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL a_we sel%0d: got %b want 1", s, rf_we); end
            n_vec++; if (rf_waddr !== exp_addr[s]) begin n_fail++; $display("FAIL a_waddr sel%0d: got %0d want %0d", s, rf_waddr, exp_addr[s]); end
            n_vec++; if (rf_wdata !== 32'hA000_0000 + 32'(s)) begin n_fail++; $display("FAIL a_wdata sel%0d: got %h", s, rf_wdata); end
        end
        // Destination r0: the write is suppressed
        a_instr = 32'h0000_0000;
        a_sel   = 2'b00;
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL a_r0_we: got %b want 0", rf_we); end
        idle();
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL a_idle_we: got %b want 0", rf_we); end
    endtask

    task automatic test_b_push();
        do_reset();
        b_valid = 1'b1;
        b_dest  = 5'd5;
        b_data  = 32'hDEADBEEF;
        tick();
        idle();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL b_latency_early: got %b want 0", rf_we); end
        tick();
        n_vec++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL b_we: got %b want 1", rf_we); end
        n_vec++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL b_waddr: got %0d want 5", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b_wdata: got %h want deadbeef", rf_wdata); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        b_issue = 1'b1;
        b_issue_dest = 5'd5;
        tick();
        idle();
        n_vec++; if (busy !== 32'h0000_0020) begin n_fail++; $display("FAIL sb_set: got %h want 00000020", busy); end
        b_valid = 1'b1;
        b_dest  = 5'd5;
        b_data  = 32'h5555_0001;
        tick();
        idle();
        n_vec++; if (busy !== 32'h0000_0020) begin n_fail++; $display("FAIL sb_hold: got %h want 00000020", busy); end
        tick();
        n_vec++; if (busy !== 32'd0) begin n_fail++; $display("FAIL sb_clear: got %h want 0", busy); end
        // Set and clear of the same register in one cycle: set wins
        b_issue = 1'b1;
        b_issue_dest = 5'd7;
        tick();
        idle();
        b_valid = 1'b1;
        b_dest  = 5'd7;
        tick();
        idle();
        b_issue = 1'b1;
        b_issue_dest = 5'd7;
        tick();
        idle();
        n_vec++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set_wins: got %h want 00000080", busy); end
        // Register 0 is never marked busy
        b_issue = 1'b1;
        b_issue_dest = 5'd0;
        tick();
        idle();
        n_vec++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_r0: got %h want 00000080", busy); end
    endtask

    task automatic test_queue_full();
        do_reset();
        a_valid = 1'b1;
        a_instr = 32'h0000_1800;
        a_sel   = 2'b00;
        a_data  = 32'h0A0A_0A0A;
        for (int k = 1; k <= 3; k++) begin
            b_valid = 1'b1;
            b_dest  = 5'(k);
            b_data  = 32'hB000_0000 + 32'(k);
            tick();
            if (k >= 2) begin
                n_vec++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL full_b_ready k%0d: got %b want 0", k, b_ready); end
            end
        end
        n_vec++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL full_a_wins: got %0d want 3", rf_waddr); end
        idle();
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'hB000_0000 + 32'(k))
                begin n_fail++; $display("FAIL full_drain%0d: got we=%b addr=%0d data=%h want addr=%0d", k, rf_we, rf_waddr, rf_wdata, k); end
        end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_third_dropped: got %b want 0", rf_we); end
        n_vec++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b want 1", b_ready); end
    endtask

    task automatic test_starvation();
        do_reset();
        a_valid = 1'b1;
        a_instr = 32'h0000_1800;
        a_sel   = 2'b00;
        a_data  = 32'h1111_1111;
        b_valid = 1'b1;
        b_dest  = 5'd9;
        b_data  = 32'hCAFE_0009;
        tick();
        b_valid = 1'b0;
        for (int i = 1; i <= c_STARVE; i++) begin
            tick();
            n_vec++; if (stall_a !== (i == c_STARVE)) begin n_fail++; $display("FAIL starve_stall wait%0d: got %b want %b", i, stall_a, (i == c_STARVE)); end
            n_vec++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL starve_a_wins wait%0d: got %0d want 3", i, rf_waddr); end
        end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL starve_err_early: got %b want 0", err); end
        a_data = 32'h2222_2222;
        tick();
        a_valid = 1'b0;
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hCAFE_0009)
            begin n_fail++; $display("FAIL starve_forced_b: got we=%b addr=%0d data=%h want 9 cafe0009", rf_we, rf_waddr, rf_wdata); end
        n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL starve_err: got %b want 1", err); end
        n_vec++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL starve_one_cycle: got %b want 0", stall_a); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL starve_a_dropped: got %b want 0", rf_we); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_valid = 1'b1;
        a_instr = 32'h0000_1800;
        b_valid = 1'b1;
        b_issue = 1'b1;
        b_dest  = 5'd4;
        b_issue_dest = 5'd4;
        tick();
        b_dest  = 5'd6;
        b_issue_dest = 5'd6;
        tick();
        idle();
        n_vec++; if (b_ready !== 1'b0 || busy !== 32'h0000_0050)
            begin n_fail++; $display("FAIL mid_setup: got ready=%b busy=%h want 0 00000050", b_ready, busy); end
        rst = 1'b1;
        #1;
        n_vec++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", b_ready); end
        n_vec++; if (busy !== 32'd0) begin n_fail++; $display("FAIL mid_rst_busy: got %h want 0", busy); end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_b_write cyc%0d: got %b want 0", i, rf_we); end
        end
    endtask

    task automatic test_random();
        logic [36:0] mq[$];
        logic [36:0] hd;
        int          cnt;
        bit          frc;
        bit          drain;
        int          sz;
        logic [4:0]  ad;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_busy;
        logic        e_err;
        do_reset();
        mq.delete();
        cnt = 0; frc = 0; e_we = 0; e_waddr = 0; e_wdata = 0; e_busy = 0; e_err = 0;
        for (int blk = 0; blk < 20; blk++) begin
            int pa;
            case ($urandom_range(0, 3))
                0:       pa = 25;
                1:       pa = 50;
                2:       pa = 90;
                default: pa = 100;
            endcase
            for (int c = 0; c < 100; c++) begin
                a_valid      = ($urandom_range(0, 99) < pa);
                a_instr      = $urandom;
                a_sel        = 2'($urandom_range(0, 3));
                a_data       = $urandom;
                b_issue      = ($urandom_range(0, 9) < 3);
                b_issue_dest = 5'($urandom_range(0, 31));
                b_valid      = ($urandom_range(0, 9) < 5);
                b_dest       = 5'($urandom_range(0, 31));
                b_data       = $urandom;
                sz = mq.size();
                n_vec++; if (b_ready !== (sz < 2)) begin n_fail++; $display("FAIL rnd_b_ready blk%0d c%0d: got %b want %b", blk, c, b_ready, (sz < 2)); end
                n_vec++; if (stall_a !== frc) begin n_fail++; $display("FAIL rnd_stall blk%0d c%0d: got %b want %b", blk, c, stall_a, frc); end
                // Reference: who owns the port this cycle
                drain = frc ? (sz > 0) : (!a_valid && sz > 0);
                if (frc && a_valid) e_err = 1'b1;
                if (!frc && a_valid) begin
                    case (a_sel)
                        2'd0:    ad = a_instr[15:11];
                        2'd1:    ad = a_instr[20:16];
                        2'd2:    ad = 5'd31;
                        default: ad = a_instr[25:21];
                    endcase
                    e_we = (ad != 5'd0); e_waddr = ad; e_wdata = a_data;
                end else if (drain) begin
                    hd = mq.pop_front();
                    e_we = (hd[36:32] != 5'd0); e_waddr = hd[36:32]; e_wdata = hd[31:0];
                    e_busy[hd[36:32]] = 1'b0;
                end else begin
                    e_we = 1'b0;
                end
                if (b_issue) e_busy[b_issue_dest] = 1'b1;
                e_busy[0] = 1'b0;
                if (b_valid && sz < 2) mq.push_back({b_dest, b_data});
                if (sz > 0 && !drain) cnt = cnt + 1; else cnt = 0;
                frc = !frc && (cnt == c_STARVE);
                tick();
                n_vec++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rnd_we blk%0d c%0d: got %b want %b", blk, c, rf_we, e_we); end
                if (e_we) begin
                    n_vec++; if (rf_waddr !== e_waddr || rf_wdata !== e_wdata)
                        begin n_fail++; $display("FAIL rnd_wr blk%0d c%0d: got %0d/%h want %0d/%h", blk, c, rf_waddr, rf_wdata, e_waddr, e_wdata); end
                end
                n_vec++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy blk%0d c%0d: got %h want %h", blk, c, busy, e_busy); end
                n_vec++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err blk%0d c%0d: got %b want %b", blk, c, err, e_err); end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_a_write();
        test_b_push();
        test_scoreboard();
        test_queue_full();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
